// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// Imported by the controller top and its ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that hold a memory request open and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the controller's ALUOp plus instruction function bits to an ALUControl code.
// Purely combinational.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  aluop_e     alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only selects sub for register-register ops; addi keeps add.
          3'b000:  alu_control_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: steps a shared ALU / unified memory datapath
// through fetch, decode, execute, memory and writeback, trapping on bad opcodes or stalls.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [8:0] LIMIT = 9'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       timeout;
  aluop_e     alu_op;
  logic       branch;
  logic       pc_update;

  // Trap fires in the cycle whose stall would bring the counter up to the limit;
  // a mem_ready in that same cycle completes the access instead.
  assign timeout = (LIMIT != 9'd0) && !mem_ready && (({1'b0, wait_cnt_q} + 9'd1) == LIMIT);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECR: state_d = S_ALUWB;
      S_EXECI: state_d = S_ALUWB;
      S_ALUWB: state_d = S_FETCH;
      S_BEQ:   state_d = S_FETCH;
      S_JAL:   state_d = S_ALUWB;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (is_mem_state(state_q) && !mem_ready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    branch    = 1'b0;
    pc_update = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE: ImmSrc = IMM_S;
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

  assign PCWrite    = (branch && zero) || pc_update;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

  mc_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (opcode[5]),
    .alu_control_o (ALUControl)
  );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle RV32I core variant. It replaces the single-cycle control path and shares one ALU and one unified instruction/data memory across cycles.
- It decodes the instruction register and steps the datapath through Fetch/Decode/Execute/Memory/Writeback, driving one set of mux selects and write strobes per cycle.
- It handshakes with memory through a req/ready pair, and traps on illegal opcodes or memory timeout.

Parameters:
- WAIT_LIMIT, 0, maximum cycles to wait for mem_ready in any memory state (1..255). 0 means wait forever.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  7  instr[6:0] from instruction register.
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- MemWrite  output  1  store strobe, qualified by mem_req.
- AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address.
- IRWrite  output  1  load instruction register and OldPC.
- PCWrite  output  1  PC register enable.
- RegWrite  output  1  register-file write enable.
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 (A).
- ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4.
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- trap  output  1  sticky; high in TRAP state.
- trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are combinational from state, opcode/funct and zero/mem_ready.
- Reset: while rst_n is low at a clock edge, the next state is FETCH, the wait counter clears and trap_cause is 00. Reset mid-access abandons the access and nothing is written. The first cycle after reset is FETCH.
- ImmSrc is decoded from opcode in every state: lw/addi 00, sw 01, beq 10, jal 11, otherwise 00.
- Branch and PCUpdate are internal signals. PCWrite = (Branch & zero) | PCUpdate.
- ALUOp is internal. 00 gives add. 01 gives sub. 10 decodes funct3:
  - 000: sub if funct7b5 & opcode[5], else add.
  - 010: slt. 110: or. 111: and. Others: add.
- States and outputs (unlisted strobes are 0; unlisted selects are 00):
  - FETCH: mem_req, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate only when mem_ready. Stay until mem_ready, then go to DECODE.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Anything else → TRAP with cause 01.
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00. Next is MEMREAD if opcode is 0000011, else MEMWRITE.
  - MEMREAD: mem_req, AdrSrc=1. Stay until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Next is FETCH.
  - MEMWRITE: mem_req, MemWrite, AdrSrc=1. Stay until mem_ready, then FETCH.
  - EXECR: SrcA=10, SrcB=00, ALUOp=10. Next is ALUWB.
  - EXECI: SrcA=10, SrcB=01, ALUOp=10. Next is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Next is FETCH.
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch. Next is FETCH.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. Next is ALUWB.
  - TRAP: all strobes and mem_req are 0. trap=1. Stays in TRAP until reset.
- Latency:
  - Zero-wait memory gives beq 3 cycles, R/I/jal/sw 4 cycles, lw 5 cycles.
  - Each mem_ready-low cycle adds one cycle.
- Wait counter (8-bit):
  - Increments each cycle in a memory state while mem_ready is 0.
  - Clears on state change.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with mem_ready still 0, go to TRAP with cause 10.
  - mem_ready in that same cycle wins over the timeout.
- mem_ready outside a memory state is ignored.

Decomposition:
- Package mc_pkg holds:
  - The state enum.
  - Opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL).
  - ALUControl, ResultSrc, SrcA, SrcB and ImmSrc encodings.
  - Trap cause codes.
- One sub-module, mc_alu_decoder, maps (ALUOp, funct3, funct7b5, opcode[5]) to ALUControl combinationally.

Test Plan:
- addi, mem_ready always 1 → FETCH,DECODE,EXECI,ALUWB. RegWrite high exactly in cycle 4. ALUControl=000 in EXECI.
- lw, mem_ready low for 3 cycles in MEMREAD → MEMREAD held 4 cycles with mem_req=1, AdrSrc=1. Then MEMWB with ResultSrc=01, RegWrite=1. 8 cycles total.
- beq with zero=1, then with zero=0 → PCWrite=1 in BEQ for the first case and 0 for the second. ALUControl=001 in both.
- R-type sub (funct3 000, funct7b5=1) → ALUControl=001. Same with opcode 0010011 → 000.
- opcode 1111111 → TRAP after DECODE, trap_cause=01, no strobes for 20 cycles. Then rst_n=0 for 1 cycle → FETCH.
- WAIT_LIMIT=4, sw with mem_ready stuck at 0 → trap_cause=10 after 4 wait cycles, MemWrite deasserted. Separately, rst_n low during MEMREAD → FETCH next cycle, no RegWrite.
